pwm_cfg_seq: RTL and testbench

PWM_CFG_SEQ -- requirements
Module: pwm_cfg_seq

---
 rtl/pwm_pkg.sv | 43 ++++
 rtl/pwm_cfg_seq_if.sv | 34 +++
 rtl/pwm_cfg_seq.sv | 141 ++++++++++++++
 tb/tb_pwm_cfg_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM register map, sequencer state enum and profile type
//
// Purpose: single source of truth for PWM register-file addresses, the
// profile-load sequencer states and the number of load steps.
// Ports: none (package).

package pwm_pkg;

  // PWM register-file map
  localparam logic [5:0] ADDR_PERIOD_LO    = 6'h00;
  localparam logic [5:0] ADDR_PERIOD_HI    = 6'h01;
  localparam logic [5:0] ADDR_COUNTER_EN   = 6'h02;
  localparam logic [5:0] ADDR_COMPARE1_LO  = 6'h03;
  localparam logic [5:0] ADDR_COMPARE1_HI  = 6'h04;
  localparam logic [5:0] ADDR_COMPARE2_LO  = 6'h05;
  localparam logic [5:0] ADDR_COMPARE2_HI  = 6'h06;
  localparam logic [5:0] ADDR_COUNTER_RST  = 6'h07;
  localparam logic [5:0] ADDR_COUNTER_LO   = 6'h08;
  localparam logic [5:0] ADDR_COUNTER_HI   = 6'h09;
  localparam logic [5:0] ADDR_PRESCALE     = 6'h0A;
  localparam logic [5:0] ADDR_UPNOTDOWN    = 6'h0B;
  localparam logic [5:0] ADDR_PWM_EN       = 6'h0C;
  localparam logic [5:0] ADDR_FUNCTIONS    = 6'h0D;

  // Number of register writes in one profile load
  localparam int unsigned NUM_STEPS = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WRAP = 2'd1,
    WRITE     = 2'd2,
    DONE      = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [15:0] period;
    logic [15:0] compare1;
    logic [15:0] compare2;
    logic [7:0]  prescale;
    logic [7:0]  functions;
  } profile_t;

endpackage

// File: rtl/pwm_cfg_seq_if.sv
// rtl/pwm_cfg_seq_if.sv - host access port and register-file bus of the PWM profile sequencer
//
// Purpose: bundles the host (instruction decoder) strobes and the shared
// register-file bus driven by the sequencer.
// Signals:
//   h_read, h_write, h_addr, h_wdata : host request
//   h_rdata                          : read data returned to host
//   read, write, addr, data_write    : register-file bus request
//   data_read                        : register-file read data
// Modports: slave = the sequencer, master = host + register file side.

interface pwm_cfg_seq_if;
  logic       h_read;
  logic       h_write;
  logic [5:0] h_addr;
  logic [7:0] h_wdata;
  logic [7:0] h_rdata;

  logic       read;
  logic       write;
  logic [5:0] addr;
  logic [7:0] data_write;
  logic [7:0] data_read;

  modport slave (
    input  h_read, h_write, h_addr, h_wdata, data_read,
    output h_rdata, read, write, addr, data_write
  );

  modport master (
    output h_read, h_write, h_addr, h_wdata, data_read,
    input  h_rdata, read, write, addr, data_write
  );
endinterface

// File: rtl/pwm_cfg_seq.sv
// rtl/pwm_cfg_seq.sv - PWM profile-load sequencer sharing the register bus with a host
//
// Purpose: on start, latches a PWM profile and writes it into the PWM
// register file as 10 single-cycle writes, optionally waiting for the
// counter to wrap first. The host always has priority on the bus; a
// sequencer step that loses a cycle to the host is retried unchanged.
// Ports:
//   clk, rst_n          : clock, synchronous active-high reset
//   bus                 : host strobes + register-file bus (slave modport)
//   start, sync_wrap    : load request, wait-for-wrap select
//   p_period, p_compare1, p_compare2, p_prescale, p_functions : profile
//   count_val           : live PWM counter value
//   busy, done          : load in progress, one-cycle completion pulse
//   host_hits           : host-preempted cycles during the last load

module pwm_cfg_seq
  import pwm_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  pwm_cfg_seq_if.slave  bus,
  input  logic          start,
  input  logic          sync_wrap,
  input  logic [15:0]   p_period,
  input  logic [15:0]   p_compare1,
  input  logic [15:0]   p_compare2,
  input  logic [7:0]    p_prescale,
  input  logic [7:0]    p_functions,
  input  logic [15:0]   count_val,
  output logic          busy,
  output logic          done,
  output logic [7:0]    host_hits
);

  localparam logic [3:0] LAST_STEP = 4'(NUM_STEPS - 1);

  seq_state_e  state_q, state_d;
  logic [3:0]  step_q, step_d;
  profile_t    prof_q, prof_d;
  logic [7:0]  hits_q, hits_d;

  logic        host_act;
  logic        seq_wr;

  // Step index -> {addr, data}. PWM output is disabled first and re-enabled
  // last so the intermediate mixed old/new profile never drives the pin.
  function automatic logic [13:0] step_word(input logic [3:0] step, input profile_t p);
    logic [13:0] w;
    w = '0;
    case (step)
      4'd0:    w = {ADDR_PWM_EN,      8'h00};
      4'd1:    w = {ADDR_PERIOD_LO,   p.period[7:0]};
      4'd2:    w = {ADDR_PERIOD_HI,   p.period[15:8]};
      4'd3:    w = {ADDR_COMPARE1_LO, p.compare1[7:0]};
      4'd4:    w = {ADDR_COMPARE1_HI, p.compare1[15:8]};
      4'd5:    w = {ADDR_COMPARE2_LO, p.compare2[7:0]};
      4'd6:    w = {ADDR_COMPARE2_HI, p.compare2[15:8]};
      4'd7:    w = {ADDR_FUNCTIONS,   p.functions};
      4'd8:    w = {ADDR_PRESCALE,    p.prescale};
      4'd9:    w = {ADDR_PWM_EN,      8'h01};
      default: w = '0;
    endcase
    return w;
  endfunction

  assign host_act    = bus.h_read | bus.h_write;
  assign bus.h_rdata = bus.data_read;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      prof_q  <= '0;
      hits_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      prof_q  <= prof_d;
      hits_q  <= hits_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    prof_d  = prof_q;
    hits_d  = hits_q;
    seq_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          prof_d = '{period:    p_period,
                     compare1:  p_compare1,
                     compare2:  p_compare2,
                     prescale:  p_prescale,
                     functions: p_functions};
          hits_d  = '0;
          step_d  = '0;
          state_d = sync_wrap ? WAIT_WRAP : WRITE;
        end
      end
      WAIT_WRAP: begin
        if (count_val == 16'h0000) state_d = WRITE;
      end
      WRITE: begin
        if (host_act) begin
          // Host owns this cycle; hold the step and record the stall
          if (hits_q != 8'hFF) hits_d = hits_q + 8'd1;
        end else begin
          seq_wr = 1'b1;
          if (step_q == LAST_STEP) state_d = DONE;
          else                     step_d  = step_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus mux: host first, then sequencer, otherwise all zero
  always_comb begin
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.addr       = '0;
    bus.data_write = '0;
    if (host_act) begin
      bus.read       = bus.h_read;
      bus.write      = bus.h_write;
      bus.addr       = bus.h_addr;
      bus.data_write = bus.h_wdata;
    end else if (seq_wr) begin
      bus.write                   = 1'b1;
      {bus.addr, bus.data_write}  = step_word(step_q, prof_q);
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign host_hits = hits_q;

endmodule

// File: tb/tb_pwm_cfg_seq.sv
// tb/tb_pwm_cfg_seq.sv - directed self-checking bench for pwm_cfg_seq

module tb_pwm_cfg_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sync_wrap;
  logic [15:0] p_period, p_compare1, p_compare2;
  logic [7:0]  p_prescale, p_functions;
  logic [15:0] count_val;
  logic        busy, done;
  logic [7:0]  host_hits;

  pwm_cfg_seq_if bus();

  pwm_cfg_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .start       (start),
    .sync_wrap   (sync_wrap),
    .p_period    (p_period),
    .p_compare1  (p_compare1),
    .p_compare2  (p_compare2),
    .p_prescale  (p_prescale),
    .p_functions (p_functions),
    .count_val   (count_val),
    .busy        (busy),
    .done        (done),
    .host_hits   (host_hits)
  );

  // Expected writes for period=0x1234 cmp1=0x0400 cmp2=0x0800 presc=3 func=0x02
  localparam logic [7:0] STD_A [10] = '{8'h0C, 8'h00, 8'h01, 8'h03, 8'h04,
                                        8'h05, 8'h06, 8'h0D, 8'h0A, 8'h0C};
  localparam logic [7:0] STD_D [10] = '{8'h00, 8'h34, 8'h12, 8'h00, 8'h04,
                                        8'h00, 8'h08, 8'h02, 8'h03, 8'h01};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int s_cyc   = 0;

  int         wc[$];
  logic [7:0] wa[$];
  logic [7:0] wd[$];
  int         dc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.write) begin
      wc.push_back(cyc);
      wa.push_back({2'b00, bus.addr});
      wd.push_back(bus.data_write);
    end
    if (done) dc.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    start         = 1'b0;
    bus.h_read    = 1'b0;
    bus.h_write   = 1'b0;
    bus.h_addr    = '0;
    bus.h_wdata   = '0;
  endtask

  // Runs one load for max_k cycles after the start cycle (k=0).
  // host_at/host_n: host write of 0x01 to 0x02 in cycles [host_at, host_at+host_n)
  // restart_at: extra start pulse with a different profile; reset_at: rst_n pulse
  task automatic run_load(input bit sync, input int host_at, input int host_n,
                          input int restart_at, input int reset_at, input int max_k);
    wc.delete(); wa.delete(); wd.delete(); dc.delete();
    @(posedge clk); #1;
    s_cyc       = cyc;
    start       = 1'b1;
    sync_wrap   = sync;
    p_period    = 16'h1234;
    p_compare1  = 16'h0400;
    p_compare2  = 16'h0800;
    p_prescale  = 8'h03;
    p_functions = 8'h02;
    count_val   = sync ? 16'd5 : 16'h0077;
    for (int k = 1; k <= max_k; k++) begin
      @(posedge clk); #1;
      start = (k == restart_at);
      if (k == restart_at) begin
        p_period    = 16'hFFFF;
        p_compare1  = 16'hEEEE;
        p_compare2  = 16'hDDDD;
        p_prescale  = 8'hCC;
        p_functions = 8'hBB;
      end
      bus.h_write = (k >= host_at) && (k < host_at + host_n);
      bus.h_addr  = bus.h_write ? 6'h02 : 6'h00;
      bus.h_wdata = bus.h_write ? 8'h01 : 8'h00;
      rst_n       = (k == reset_at);
      if (sync) count_val = (k < 5) ? 16'(5 - k) : (k == 5 ? 16'h0000 : 16'h00FF);
      if (k == reset_at + 1) begin
        #1;
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_bus_write", {31'b0, bus.write}, 32'd0);
        check_eq("rst_bus_addr", {26'b0, bus.addr}, 32'd0);
      end
    end
    idle_inputs();
    rst_n = 1'b0;
  endtask

  // Compares the log against the 10 standard writes starting at first_off
  task automatic check_std(input string tag, input int first_off, input int done_off);
    check_eq({tag, "_nwr"}, wa.size(), 32'd10);
    for (int i = 0; i < 10 && i < wa.size(); i++)
      check_eq($sformatf("%s_w%0d", tag, i),
               {8'(wc[i] - s_cyc), 8'h00, wa[i], wd[i]},
               {8'(first_off + i), 8'h00, STD_A[i], STD_D[i]});
    check_eq({tag, "_ndone"}, dc.size(), 32'd1);
    if (dc.size() > 0)
      check_eq({tag, "_done_lat"}, dc[0] - s_cyc + 1, done_off + 1);
  endtask

  initial begin
    idle_inputs();
    rst_n         = 1'b1;
    sync_wrap     = 1'b0;
    p_period      = '0;
    p_compare1    = '0;
    p_compare2    = '0;
    p_prescale    = '0;
    p_functions   = '0;
    count_val     = 16'h0077;
    bus.data_read = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", {31'b0, busy}, 32'd0);
    check_eq("reset_done", {31'b0, done}, 32'd0);
    check_eq("reset_hits", {24'b0, host_hits}, 32'd0);
    check_eq("reset_bus", {bus.read, bus.write, bus.addr, bus.data_write}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_bus", {bus.read, bus.write, bus.addr, bus.data_write}, 32'd0);
    bus.data_read = 8'hA7;
    #1 check_eq("rdata_fwd", {24'b0, bus.h_rdata}, 32'h0000_00A7);

    // Basic load: writes on start+1..start+10, done at start+11 (12 cycles)
    run_load(1'b0, 0, 0, -1, -1, 20);
    check_std("basic", 1, 11);
    check_eq("basic_hits", {24'b0, host_hits}, 32'd0);
    check_eq("basic_busy_end", {31'b0, busy}, 32'd0);

    // Host preemption in cycles 3..4: stalls step 2 by two cycles
    run_load(1'b0, 3, 2, -1, -1, 20);
    check_eq("host_nwr", wa.size(), 32'd12);
    for (int j = 0; j < 12 && j < wa.size(); j++) begin
      int idx;
      idx = (j < 2) ? j : j - 2;
      if (j == 2 || j == 3)
        check_eq($sformatf("host_w%0d", j), {8'(wc[j] - s_cyc), 8'h00, wa[j], wd[j]},
                 {8'(j + 1), 8'h00, 8'h02, 8'h01});
      else
        check_eq($sformatf("host_w%0d", j), {8'(wc[j] - s_cyc), 8'h00, wa[j], wd[j]},
                 {8'(j + 1), 8'h00, STD_A[idx], STD_D[idx]});
    end
    check_eq("host_ndone", dc.size(), 32'd1);
    if (dc.size() > 0) check_eq("host_done_lat", dc[0] - s_cyc + 1, 32'd14);
    check_eq("host_hits", {24'b0, host_hits}, 32'd2);

    // Wait for wrap: count 5..0, zero sampled at end of cycle 5, first write cycle 6
    run_load(1'b1, 0, 0, -1, -1, 20);
    check_std("wrap", 6, 16);
    check_eq("wrap_hits_cleared", {24'b0, host_hits}, 32'd0);

    // Second start mid-load with a different profile is ignored
    run_load(1'b0, 0, 0, 5, -1, 20);
    check_std("restart", 1, 11);

    // Reset during cycle 6: write of step 5 still visible, nothing after
    run_load(1'b0, 0, 0, -1, 6, 20);
    check_eq("rst_nwr", wa.size(), 32'd6);
    for (int i = 0; i < 6 && i < wa.size(); i++)
      check_eq($sformatf("rst_w%0d", i), {8'(wc[i] - s_cyc), 8'h00, wa[i], wd[i]},
               {8'(i + 1), 8'h00, STD_A[i], STD_D[i]});
    check_eq("rst_ndone", dc.size(), 32'd0);
    @(posedge clk); #1;
    bus.h_read    = 1'b1;
    bus.h_addr    = 6'h00;
    bus.data_read = 8'h5A;
    #1;
    check_eq("hread_bus", {bus.read, bus.write, bus.addr}, {1'b1, 1'b0, 6'h00});
    check_eq("hread_rdata", {24'b0, bus.h_rdata}, 32'h0000_005A);
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
